// File: rtl/ir_pkg.sv
// ir_pkg: shared NEC transmit definitions (state encodings, unit counts).
// Used by ir_transmitter and ir_carrier_gen.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LEAD_MARK  = 3'd1,
    ST_LEAD_SPACE = 3'd2,
    ST_BIT_MARK   = 3'd3,
    ST_BIT_SPACE  = 3'd4,
    ST_STOP_MARK  = 3'd5,
    ST_GAP        = 3'd6,
    ST_BAD        = 3'd7
  } ir_state_e;

  localparam int unsigned LEAD_MARK_UNITS  = 16;
  localparam int unsigned LEAD_SPACE_UNITS = 8;
  localparam int unsigned BIT_MARK_UNITS   = 1;
  localparam int unsigned ZERO_SPACE_UNITS = 1;
  localparam int unsigned ONE_SPACE_UNITS  = 3;
  localparam int unsigned STOP_UNITS       = 1;
  localparam int unsigned NEC_BITS         = 32;

  function automatic logic is_mark(input ir_state_e st);
    return (st == ST_LEAD_MARK) ||
           (st == ST_BIT_MARK)  ||
           (st == ST_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: free-running carrier whose phase restarts on restart_in.
// Ports: clk_in, rst_in (sync, high), restart_in, carrier_out.
module ir_carrier_gen
  import ir_pkg::*;
#(
  parameter int unsigned CARRIER_PERIOD = 2632,
  parameter int unsigned CARRIER_HIGH   = 877
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic restart_in,
  output logic carrier_out
);

  localparam int PH_W =
    (CARRIER_PERIOD > 1) ? $clog2(CARRIER_PERIOD) : 1;
  localparam logic [PH_W-1:0] PH_LAST =
    PH_W'(CARRIER_PERIOD - 1);

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;
  logic [PH_W-1:0] phase_now;

  // restart_in marks phase 0 of the current cycle, so the
  // LED is on in the very first cycle of every mark.
  always_comb begin
    phase_now = restart_in ? '0 : phase_q;
    phase_d   = (phase_now == PH_LAST) ?
                '0 : phase_now + 1'b1;
  end

  assign carrier_out =
    (int'(phase_now) < int'(CARRIER_HIGH));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/ir_transmitter.sv
// ir_transmitter: NEC IR sender (leader, 32 bits MSB first, stop, gap).
// Ports: clk_in, rst_in, code_in/valid_in/ready_out, ir_out, env_out,
// busy_out, state_out. `IR_TX_CARRIER_EN adds the 38 kHz carrier.
module ir_transmitter
  import ir_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES    = 56250,
  parameter int unsigned CARRIER_PERIOD = 2632,
  parameter int unsigned CARRIER_HIGH   = 877,
  parameter int unsigned GAP_UNITS      = 72
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        ir_out,
  output logic        env_out,
  output logic        busy_out,
  output logic [2:0]  state_out
);

  localparam int unsigned MAX_UNITS =
    (GAP_UNITS > LEAD_MARK_UNITS) ?
    GAP_UNITS : LEAD_MARK_UNITS;
  localparam int CYC_W  = $clog2(UNIT_CYCLES + 1);
  localparam int UNIT_W = $clog2(MAX_UNITS + 1);
  localparam logic [CYC_W-1:0] CYC_LOAD =
    CYC_W'(UNIT_CYCLES - 1);

  if (UNIT_CYCLES == 0 || GAP_UNITS == 0 ||
      CARRIER_PERIOD == 0 ||
      CARRIER_HIGH > CARRIER_PERIOD) begin : g_bad_cfg
    $error("ir_transmitter: bad parameters");
  end

  ir_state_e         state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [UNIT_W-1:0] units_q, units_d;
  logic [5:0]        bits_q, bits_d;
  logic [31:0]       shift_q, shift_d;

  logic              load;
  ir_state_e         ld_st;
  int unsigned       ld_units;
  logic              unit_done;
  logic              state_done;

  assign unit_done  = (cyc_q == '0);
  assign state_done = unit_done && (units_q == '0);

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    units_d  = units_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    load     = 1'b0;
    ld_st    = ST_IDLE;
    ld_units = 1;

    // Common unit timing for every timed state.
    if (state_q != ST_IDLE && state_q != ST_BAD &&
        !state_done) begin
      if (!unit_done) begin
        cyc_d = cyc_q - 1'b1;
      end else begin
        units_d = units_q - 1'b1;
        cyc_d   = CYC_LOAD;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        if (valid_in) begin
          shift_d  = code_in;
          bits_d   = 6'(NEC_BITS);
          load     = 1'b1;
          ld_st    = ST_LEAD_MARK;
          ld_units = LEAD_MARK_UNITS;
        end
      end
      ST_LEAD_MARK: begin
        if (state_done) begin
          load     = 1'b1;
          ld_st    = ST_LEAD_SPACE;
          ld_units = LEAD_SPACE_UNITS;
        end
      end
      ST_LEAD_SPACE: begin
        if (state_done) begin
          load     = 1'b1;
          ld_st    = ST_BIT_MARK;
          ld_units = BIT_MARK_UNITS;
        end
      end
      ST_BIT_MARK: begin
        if (state_done) begin
          load     = 1'b1;
          ld_st    = ST_BIT_SPACE;
          ld_units = shift_q[31] ?
                     ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
        end
      end
      ST_BIT_SPACE: begin
        if (state_done) begin
          bits_d   = bits_q - 6'd1;
          shift_d  = {shift_q[30:0], 1'b0};
          load     = 1'b1;
          ld_st    = (bits_q == 6'd1) ?
                     ST_STOP_MARK : ST_BIT_MARK;
          ld_units = (bits_q == 6'd1) ?
                     STOP_UNITS : BIT_MARK_UNITS;
        end
      end
      ST_STOP_MARK: begin
        if (state_done) begin
          load     = 1'b1;
          ld_st    = ST_GAP;
          ld_units = GAP_UNITS;
        end
      end
      ST_GAP: begin
        if (state_done) begin
          state_d = ST_IDLE;
          cyc_d   = '0;
          units_d = '0;
          bits_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
        units_d = '0;
        bits_d  = '0;
        shift_d = '0;
      end
    endcase

    if (load) begin
      state_d = ld_st;
      units_d = UNIT_W'(ld_units - 1);
      cyc_d   = CYC_LOAD;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      units_q <= '0;
      bits_q  <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      units_q <= units_d;
      bits_q  <= bits_d;
      shift_q <= shift_d;
    end
  end

  assign env_out   = is_mark(state_q);
  assign ready_out = (state_q == ST_IDLE);
  assign busy_out  = (state_q != ST_IDLE);
  assign state_out = state_q;

`ifdef IR_TX_CARRIER_EN
  logic first_q;
  logic first_d;
  logic carrier;

  // High only in the first cycle of a mark; realigns the carrier.
  assign first_d = load && is_mark(ld_st);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      first_q <= 1'b0;
    end else begin
      first_q <= first_d;
    end
  end

  ir_carrier_gen #(
    .CARRIER_PERIOD (CARRIER_PERIOD),
    .CARRIER_HIGH   (CARRIER_HIGH)
  ) u_carrier (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .restart_in  (first_q),
    .carrier_out (carrier)
  );

  assign ir_out = env_out & carrier;
`else
  assign ir_out = env_out;
`endif

endmodule

// File: tb/tb_ir_transmitter.sv
// tb_ir_transmitter: random and directed NEC frames checked cycle by
// cycle against a segment-list model, plus a pulse-width decode of env_out.
module tb_ir_transmitter;

  localparam int U = 10;
  localparam int P = 4;
  localparam int H = 1;
  localparam int G = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] code;
  logic        valid;
  logic        ready_out;
  logic        ir_out;
  logic        env_out;
  logic        busy_out;
  logic [2:0]  state_out;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [2:0] st;
    logic       env;
    logic       ir;
  } exp_t;

  exp_t exp_q[$];
  logic env_log[$];

  always #5 clk = ~clk;

  ir_transmitter #(
    .UNIT_CYCLES    (U),
    .CARRIER_PERIOD (P),
    .CARRIER_HIGH   (H),
    .GAP_UNITS      (G)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .code_in   (code),
    .valid_in  (valid),
    .ready_out (ready_out),
    .ir_out    (ir_out),
    .env_out   (env_out),
    .busy_out  (busy_out),
    .state_out (state_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic add_seg(input int st, input int units);
    bit mark;
    logic irv;
    mark = (st == 1) || (st == 3) || (st == 5);
    for (int k = 0; k < units * U; k++) begin
`ifdef IR_TX_CARRIER_EN
      irv = mark && ((k % P) < H);
`else
      irv = mark;
`endif
      exp_q.push_back('{st: 3'(st), env: mark, ir: irv});
    end
  endtask

  task automatic build(input logic [31:0] c);
    exp_q.delete();
    add_seg(1, 16);
    add_seg(2, 8);
    for (int b = 31; b >= 0; b--) begin
      add_seg(3, 1);
      add_seg(4, c[b] ? 3 : 1);
    end
    add_seg(5, 1);
    add_seg(6, G);
  endtask

  // Recover the word from envelope run lengths, like a receiver would.
  task automatic decode_chk(input logic [31:0] c);
    int lens[$];
    int n;
    logic cur;
    logic [31:0] w;
    n = 0;
    cur = env_log[0];
    foreach (env_log[i]) begin
      if (env_log[i] === cur) begin
        n++;
      end else begin
        lens.push_back(n);
        cur = env_log[i];
        n = 1;
      end
    end
    lens.push_back(n);
    if (lens.size() < 68) begin
      chk("decode_runs", lens.size(), 68);
      return;
    end
    chk("lead_mark_len", lens[0], 16 * U);
    chk("lead_space_len", lens[1], 8 * U);
    w = '0;
    for (int j = 0; j < 32; j++) begin
      w = {w[30:0], (lens[3 + 2 * j] > 2 * U)};
    end
    chk("decode_word", w, c);
    chk("stop_len", lens[66], U);
  endtask

  task automatic run_frame(input logic [31:0] c,
                           input bit hold,
                           input int pulse_at,
                           input int abort_at);
    bit ok;
    exp_t e;
    build(c);
    chk("ready_pre", ready_out, 1);
    code  = c;
    valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid = 1'b0;
    ok = 1'b1;
    env_log.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ir", ir_out, 0);
        chk("rst_env", env_out, 0);
        chk("rst_state", state_out, 0);
        chk("rst_ready", ready_out, 1);
        chk("rst_busy", busy_out, 0);
        return;
      end
      e = exp_q[i];
      if (ok) begin
        total++;
        assert ({state_out, env_out, ir_out, busy_out, ready_out}
                === {e.st, e.env, e.ir, 2'b10}) else begin
          bad++;
          ok = 1'b0;
          $error("FAIL frame %h cyc %0d: got st%0d env%b ir%b bsy%b rdy%b expected st%0d env%b ir%b bsy1 rdy0",
                 c, i, state_out, env_out, ir_out, busy_out,
                 ready_out, e.st, e.env, e.ir);
        end
      end
      env_log.push_back(env_out);
      if (i == pulse_at) begin
        code  = ~c;
        valid = 1'b1;
      end else if (i == pulse_at + 1) begin
        valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("end_state", state_out, 0);
    chk("end_ready", ready_out, 1);
    chk("end_busy", busy_out, 0);
    chk("end_env", env_out, 0);
    decode_chk(c);
  endtask

  function automatic int bit10_space(input logic [31:0] c);
    int idx;
    idx = 24 * U;
    for (int b = 31; b > 10; b--) begin
      idx += U + (c[b] ? 3 * U : U);
    end
    return idx + U + 2;
  endfunction

  initial begin
    logic [31:0] r;
    rst   = 1'b1;
    valid = 1'b0;
    code  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_state", state_out, 0);
    chk("reset_ready", ready_out, 1);
    chk("reset_busy", busy_out, 0);
    chk("reset_env", env_out, 0);
    chk("reset_ir", ir_out, 0);
    repeat (2) @(posedge clk);
    #1;

    run_frame(32'h00FF_A25D, 1'b0, -10, -1);
    run_frame(32'h0000_0000, 1'b0, -10, -1);
    for (int k = 0; k < 3; k++) begin
      r = $urandom;
      run_frame(r, 1'b0, -10, -1);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    run_frame(32'hFFFF_FFFF, 1'b1, -10, -1);
    run_frame(32'hFFFF_FFFF, 1'b0, -10, -1);

    r = $urandom;
    run_frame(r, 1'b0, 700 + int'($urandom_range(0, 200)), -1);

    r = $urandom;
    run_frame(r, 1'b0, -10, bit10_space(r));
    run_frame(32'h1234_5678, 1'b0, -10, -1);

    run_frame(32'hDEAD_BEEF, 1'b0, -10, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_transmitter.md
# ir_transmitter

NEC-format infrared transmitter, the sending counterpart of the IR receive path (`ir_decoder`). It accepts a 32-bit code over a valid/ready handshake and serializes it as a leader, 32 pulse-distance bits and a stop mark. Marks are modulated onto a 38 kHz carrier to drive an IR LED. An unmodulated envelope output is provided for loopback into the receive path.

## Interface
- UNIT_CYCLES, 56250: clock cycles per NEC time unit (562.5 us at 100 MHz).
- CARRIER_PERIOD, 2632: carrier period in cycles (about 38 kHz).
- CARRIER_HIGH, 877: carrier high cycles per period (1/3 duty).
- GAP_UNITS, 72: minimum idle units after the stop mark before the next frame.
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-high reset.
- code_in  input  32  code to send; sampled at accept.
- valid_in  input  1  request to send code_in.
- ready_out  output  1  high only in IDLE; accept = valid_in && ready_out.
- ir_out  output  1  LED drive; high = LED on.
- env_out  output  1  mark envelope; high during every mark.
- busy_out  output  1  high in any state other than IDLE.
- state_out  output  3  current state encoding, for debug.

## Operation
- States and encodings:
  - IDLE 0
  - LEAD_MARK 1, 16 units
  - LEAD_SPACE 2, 8 units
  - BIT_MARK 3, 1 unit
  - BIT_SPACE 4, 1 unit for a 0, 3 units for a 1
  - STOP_MARK 5, 1 unit
  - GAP 6, GAP_UNITS units
- Encoding 7 is unused; if it is ever reached, the block returns to IDLE on the next cycle.
- On accept, code_in is latched into a shift register and the block enters LEAD_MARK.
- Bit order: code_in[31] is sent first and code_in[0] last. This matches the receive path's code_out ordering, so a loopback returns the same word.
- Transitions:
  - LEAD_MARK → LEAD_SPACE → BIT_MARK.
  - BIT_MARK → BIT_SPACE.
  - BIT_SPACE → BIT_MARK while bits remain; after bit 0, BIT_SPACE → STOP_MARK.
  - STOP_MARK → GAP → IDLE.
- A 6-bit bit counter counts 32 down to 0. A unit counter and a unit-count counter time every state.
- env_out is 1 in LEAD_MARK, BIT_MARK and STOP_MARK, and 0 in all other states.
- valid_in is ignored while ready_out is 0. There is no queueing and no abort.

## Timing
- Reset values: ir_out 0, env_out 0, busy_out 0, state_out 0, ready_out 1, and all counters 0.
- Reset takes effect at the next edge from any state, including mid-frame. The LED goes dark immediately and any partial frame is discarded.
- If accept occurs at edge N, then from edge N+1:
  - state_out is 1;
  - env_out is 1;
  - busy_out is 1;
  - ready_out is 0.
- Every state lasts exactly (units × UNIT_CYCLES) cycles. There is no off-by-one at state boundaries.
- Frame length from accept to IDLE is (16 + 8 + Σ(2 or 4 per bit) + 1 + GAP_UNITS) × UNIT_CYCLES. With code 0 and GAP_UNITS 72 this is 161 units.
- The carrier phase counter restarts at 0 on the first cycle of each mark. ir_out is high for cycles 0 to CARRIER_HIGH−1 of each CARRIER_PERIOD. Each mark therefore begins with the LED on.
- ir_out is 0 in every non-mark state.
- ready_out is combinational on state (state == IDLE). An accept may occur on the first IDLE cycle after GAP.

## Configuration
- `IR_TX_CARRIER_EN` defined: ir_out = env_out AND carrier.
- `IR_TX_CARRIER_EN` undefined: ir_out = env_out, with no carrier and no carrier counter logic.
- env_out behaves identically in both builds.

## Structure
- Package ir_pkg holds:
  - the state enum with explicit 3-bit encodings;
  - the NEC unit counts (LEAD_MARK_UNITS 16, LEAD_SPACE_UNITS 8, BIT_MARK_UNITS 1, ZERO_SPACE_UNITS 1, ONE_SPACE_UNITS 3, STOP_UNITS 1);
  - NEC_BITS 32.
- One sub-module, ir_carrier_gen, with inputs clk_in, rst_in and restart_in, and output carrier_out, parameterized by CARRIER_PERIOD and CARRIER_HIGH. It is instantiated only under `IR_TX_CARRIER_EN`.

## Test plan
Bench parameters: UNIT_CYCLES=10, CARRIER_PERIOD=4, CARRIER_HIGH=1, GAP_UNITS=4.
- Send 32'h00FF_A25D → env_out high 160 cycles, then low 80, then 32 marks of 10 cycles each; spaces are 30 cycles for 1-bits and 10 for 0-bits, MSB first; stop mark 10; ready_out returns after the 40-cycle gap.
- Carrier build, during any mark → ir_out pattern 1,0,0,0 repeating, restarting at 1 on each mark's first cycle; ir_out 0 in all spaces.
- valid_in held high for two frames of 32'hFFFF_FFFF → exactly two frames are sent; the second leader starts on the cycle after the first GAP ends.
- Pulse valid_in mid-frame with a new code → ignored; the transmitted bits still equal the originally latched code.
- Assert rst_in during BIT_SPACE of bit 10 → next edge ir_out=0, env_out=0, state_out=0, ready_out=1; a following send of 32'h1234_5678 is a complete, correct frame.
- Loopback of inverted env_out into ir_fsm with the receive timing for 100 MHz and default parameters; send 32'hDEAD_BEEF → code_out equals 32'hDEAD_BEEF after the stop mark.
